pool2_cu: RTL and testbench

- Control unit for the 2x2/stride-2 max-pool stage that consumes the conv-block-2 feature maps.
- It is the receiving end of the start/end handshake, so conv block 2 sees it as its "next" stage.
- It accepts start_from_previous, sequences reads of the banked IFM memory window by window, drives the max-pool datapath, and writes the pooled OFM memory.
- It then hands off downstream with its own start_to_next/end_from_next handshake.

---
 rtl/pool2_cu.sv | 190 +++++++++++++++++++
 tb/tb_pool2_cu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool2_cu.sv
// ============================================================================
// Module   : pool2_cu
// Purpose  : Control unit for the 2x2 / stride-2 max-pool stage. Accepts a
//            frame from the previous stage, walks the banked IFM memory one
//            pooling window at a time, drives the max-pool datapath and writes
//            pooled results into the OFM memory before handing off downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool2_cu #(
  parameter int IFM_SIZE         = 10,
  parameter int IFM_DEPTH        = 8,
  parameter int POOL_SIZE        = 2,
  parameter int OFM_SIZE         = IFM_SIZE / POOL_SIZE,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE),
  parameter int SEL_SIZE         = $clog2(IFM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_from_previous,
  output logic                        end_to_previous,
  input  logic                        end_from_next,
  output logic                        start_to_next,
  output logic                        ifm_enable_read,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read,
  output logic [SEL_SIZE-1:0]         ifm_sel,
  output logic                        pool_load,
  output logic                        pool_enable,
  output logic                        ofm_enable_write,
  output logic [ADDRESS_SIZE_OFM-1:0] ofm_address_write,
  output logic [SEL_SIZE-1:0]         ofm_sel
);

  localparam int CNT_W = $clog2(OFM_SIZE);
  localparam logic [CNT_W-1:0]    POS_MAX = CNT_W'(OFM_SIZE - 1);
  localparam logic [SEL_SIZE-1:0] CH_MAX  = SEL_SIZE'(IFM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_OFM  = 3'd1,
    S_READ      = 3'd2,
    S_DRAIN     = 3'd3,
    S_WAIT_NEXT = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Window position counters: w is the element inside the 2x2 window
  // (w[1] = row offset, w[0] = column offset).
  logic [1:0]          w_cnt;
  logic [CNT_W-1:0]    ocol;
  logic [CNT_W-1:0]    orow;
  logic [SEL_SIZE-1:0] ch;
  logic                drain_second;
  logic                last_read;

  // Stage 1 aligns with the memory read data, stage 2 with the pooled max.
  logic                        p1_valid;
  logic [1:0]                  p1_w;
  logic [ADDRESS_SIZE_OFM-1:0] p1_oaddr;
  logic [SEL_SIZE-1:0]         p1_osel;
  logic                        p2_write;
  logic [ADDRESS_SIZE_OFM-1:0] p2_oaddr;
  logic [SEL_SIZE-1:0]         p2_osel;

  logic [ADDRESS_SIZE_IFM-1:0] ifm_row;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_col;
  logic [ADDRESS_SIZE_OFM-1:0] ofm_addr_now;

  assign last_read = (state == S_READ) && (w_cnt == 2'd3) && (ocol == POS_MAX)
                     && (orow == POS_MAX) && (ch == CH_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake/read strobes.
  always_comb begin
    state_next      = state;
    end_to_previous = 1'b0;
    start_to_next   = 1'b0;
    ifm_enable_read = 1'b0;
    case (state)
      S_IDLE: begin
        end_to_previous = 1'b1;
        if (start_from_previous) state_next = S_WAIT_OFM;
      end
      S_WAIT_OFM: begin
        if (end_from_next) state_next = S_READ;
      end
      S_READ: begin
        ifm_enable_read = 1'b1;
        if (last_read) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_second) begin
          if (end_from_next) begin
            start_to_next = 1'b1;
            state_next    = S_IDLE;
          end else begin
            state_next = S_WAIT_NEXT;
          end
        end
      end
      S_WAIT_NEXT: begin
        if (end_from_next) begin
          start_to_next = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Marks the second of the two drain cycles.
  always_ff @(posedge clk) begin
    if (reset) drain_second <= 1'b0;
    else       drain_second <= (state == S_DRAIN) && !drain_second;
  end

  // Nested window counters; they only run while reading and sit at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset || (state != S_READ)) begin
      w_cnt <= '0;
      ocol  <= '0;
      orow  <= '0;
      ch    <= '0;
    end else begin
      w_cnt <= w_cnt + 2'd1;
      if (w_cnt == 2'd3) begin
        if (ocol == POS_MAX) begin
          ocol <= '0;
          if (orow == POS_MAX) begin
            orow <= '0;
            if (ch == CH_MAX) ch <= '0;
            else              ch <= ch + 1'b1;
          end else begin
            orow <= orow + 1'b1;
          end
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
    end
  end

  assign ifm_row = ADDRESS_SIZE_IFM'(POOL_SIZE) * ADDRESS_SIZE_IFM'(orow)
                   + ADDRESS_SIZE_IFM'(w_cnt[1]);
  assign ifm_col = ADDRESS_SIZE_IFM'(POOL_SIZE) * ADDRESS_SIZE_IFM'(ocol)
                   + ADDRESS_SIZE_IFM'(w_cnt[0]);
  assign ifm_address_read = ifm_row * ADDRESS_SIZE_IFM'(IFM_SIZE) + ifm_col;
  assign ifm_sel          = ch;
  assign ofm_addr_now     = ADDRESS_SIZE_OFM'(orow) * ADDRESS_SIZE_OFM'(OFM_SIZE)
                            + ADDRESS_SIZE_OFM'(ocol);

  // Two-stage pipeline tracking read data through the max register to the OFM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_w     <= '0;
      p1_oaddr <= '0;
      p1_osel  <= '0;
      p2_write <= 1'b0;
      p2_oaddr <= '0;
      p2_osel  <= '0;
    end else begin
      p1_valid <= ifm_enable_read;
      p1_w     <= ifm_enable_read ? w_cnt        : 2'd0;
      p1_oaddr <= ifm_enable_read ? ofm_addr_now : '0;
      p1_osel  <= ifm_enable_read ? ch           : '0;
      p2_write <= p1_valid && (p1_w == 2'd3);
      p2_oaddr <= p1_oaddr;
      p2_osel  <= p1_osel;
    end
  end

  assign pool_load         = p1_valid && (p1_w == 2'd0);
  assign pool_enable       = p1_valid && (p1_w != 2'd0);
  assign ofm_enable_write  = p2_write;
  assign ofm_address_write = p2_oaddr;
  assign ofm_sel           = p2_osel;

endmodule

`default_nettype wire

// File: tb/tb_pool2_cu.sv
// ============================================================================
// Module   : tb_pool2_cu
// Purpose  : Self-checking bench for pool2_cu. Reads and writes are checked
//            against a frame model that decodes the transaction index into
//            window coordinates with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool2_cu;

  logic       clk;
  logic       reset;
  logic       start_from_previous;
  logic       end_to_previous;
  logic       end_from_next;
  logic       start_to_next;
  logic       ifm_enable_read;
  logic [6:0] ifm_address_read;
  logic [2:0] ifm_sel;
  logic       pool_load;
  logic       pool_enable;
  logic       ofm_enable_write;
  logic [4:0] ofm_address_write;
  logic [2:0] ofm_sel;

  pool2_cu dut (
    .clk                 (clk),
    .reset               (reset),
    .start_from_previous (start_from_previous),
    .end_to_previous     (end_to_previous),
    .end_from_next       (end_from_next),
    .start_to_next       (start_to_next),
    .ifm_enable_read     (ifm_enable_read),
    .ifm_address_read    (ifm_address_read),
    .ifm_sel             (ifm_sel),
    .pool_load           (pool_load),
    .pool_enable         (pool_enable),
    .ofm_enable_write    (ofm_enable_write),
    .ofm_address_write   (ofm_address_write),
    .ofm_sel             (ofm_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Values to drive at the next falling edge.
  logic next_start = 1'b0;
  logic next_efn   = 1'b1;
  logic next_reset = 1'b1;

  // Frame model state.
  int rd_n      = 0;
  int wr_n      = 0;
  int stn_count = 0;
  bit p1_v = 0, p2_v = 0;
  int p1_w = 0, p2_w = 0;
  bit rst_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 ns later, check the
  // read/pool/write stream against the frame model.
  task automatic cycle();
    int n, w, oc, orr, c;
    @(negedge clk);
    start_from_previous = next_start;
    end_from_next       = next_efn;
    reset               = next_reset;
    next_start = 1'b0;
    next_reset = 1'b0;
    #1;
    if (rst_prev) begin
      p1_v = 0; p2_v = 0; rd_n = 0; wr_n = 0;
    end
    check("pool_load",   pool_load,        p1_v && (p1_w == 0));
    check("pool_enable", pool_enable,      p1_v && (p1_w != 0));
    check("ofm_we",      ofm_enable_write, p2_v && (p2_w == 3));
    if (ofm_enable_write) begin
      check("ofm_addr", ofm_address_write, wr_n % 25);
      check("ofm_sel",  ofm_sel,           (wr_n / 25) % 8);
      wr_n++;
    end
    p2_v = p1_v; p2_w = p1_w;
    p1_v = ifm_enable_read;
    if (ifm_enable_read) begin
      n   = rd_n % 800;
      w   = n % 4;
      oc  = (n / 4) % 5;
      orr = (n / 20) % 5;
      c   = n / 100;
      p1_w = w;
      check("ifm_addr", ifm_address_read, (2 * orr + w / 2) * 10 + 2 * oc + w % 2);
      check("ifm_sel",  ifm_sel,          c);
      rd_n++;
    end else begin
      p1_w = 0;
    end
    if (start_to_next) stn_count++;
    rst_prev = reset;
  endtask

  task automatic check_reset_outputs();
    check("rst_etp",   end_to_previous,   1);
    check("rst_stn",   start_to_next,     0);
    check("rst_re",    ifm_enable_read,   0);
    check("rst_raddr", ifm_address_read,  0);
    check("rst_rsel",  ifm_sel,           0);
    check("rst_load",  pool_load,         0);
    check("rst_en",    pool_enable,       0);
    check("rst_we",    ofm_enable_write,  0);
    check("rst_waddr", ofm_address_write, 0);
    check("rst_wsel",  ofm_sel,           0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      check("idle_etp",  end_to_previous, 1);
      check("idle_read", ifm_enable_read, 0);
    end
  endtask

  // One frame. pre_wait/post_wait: cycles end_from_next is held low before
  // reading / at the end of the frame (0 = held high). mid_start/reset_at:
  // read index at which a stray start or a reset is applied (-1 = never).
  task automatic run_frame(input int pre_wait, input int post_wait,
                           input int mid_start, input int reset_at);
    int stn0;
    rd_n = 0; wr_n = 0;
    stn0 = stn_count;
    next_start = 1'b1;
    next_efn   = (pre_wait == 0);
    cycle();
    check("start_etp", end_to_previous, 1);
    cycle();
    check("etp_fall",     end_to_previous, 0);
    check("wait_no_read", ifm_enable_read, 0);
    if (pre_wait > 0) begin
      for (int i = 1; i < pre_wait; i++) begin
        cycle();
        check("wait_no_read", ifm_enable_read, 0);
      end
      next_efn = 1'b1;
      cycle();
      check("wait_rise_no_read", ifm_enable_read, 0);
    end
    for (int k = 0; k < 800; k++) begin
      if (k == mid_start) next_start = 1'b1;
      if (k == reset_at)  next_reset = 1'b1;
      if (post_wait > 0 && k == 790) next_efn = 1'b0;
      cycle();
      check("read_active", ifm_enable_read, 1);
      check("read_etp",    end_to_previous, 0);
      if (k == reset_at) begin
        next_efn = 1'b1;
        cycle();
        check_reset_outputs();
        idle(6);
        check("rst_no_stn", stn_count - stn0, 0);
        return;
      end
    end
    check("read_count", rd_n, 800);
    cycle();
    check("drain1_read", ifm_enable_read, 0);
    check("drain1_stn",  start_to_next,   0);
    check("drain1_etp",  end_to_previous, 0);
    if (post_wait == 0) begin
      cycle();
      check("drain2_stn", start_to_next,   1);
      check("drain2_etp", end_to_previous, 0);
    end else begin
      cycle();
      check("drain2_no_stn", start_to_next, 0);
      for (int i = 1; i < post_wait; i++) begin
        cycle();
        check("wnext_stn", start_to_next,   0);
        check("wnext_etp", end_to_previous, 0);
      end
      next_efn = 1'b1;
      cycle();
      check("wnext_stn_rise", start_to_next, 1);
    end
    check("write_count", wr_n, 200);
    check("stn_once", stn_count - stn0, 1);
  endtask

  initial begin
    start_from_previous = 1'b0;
    end_from_next       = 1'b1;
    reset               = 1'b1;
    next_reset = 1'b1;
    cycle();
    next_reset = 1'b1;
    cycle();
    cycle();
    check_reset_outputs();
    idle(2);

    run_frame(0, 0, -1, -1);
    // Back-to-back frame accepted in the IDLE cycle right after start_to_next.
    run_frame(10, 0, -1, -1);
    run_frame(0, $urandom_range(3, 15), -1, -1);
    idle(1);
    run_frame(0, 0, $urandom_range(50, 700), -1);
    idle(5);
    run_frame(0, 0, -1, 300);
    run_frame(0, 0, -1, -1);
    run_frame($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(10, 790), -1);
    idle(3);
    run_frame(0, 0, -1, $urandom_range(1, 798));
    run_frame(0, 0, -1, -1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
